// File: rtl/rl_pair_scheduler.sv
// Pair-address sequencer: walks every (home, neighbor) pair and drives BRAM reads with back-pressure.
// Optional build macro RL_SKIP_SELF_EN drops h==n pairs for same-cell runs.
module rl_pair_scheduler #(
    parameter int ADDR_WIDTH     = 9,
    parameter int RD_LATENCY     = 1,
    parameter int PAIR_CNT_WIDTH = 2*ADDR_WIDTH+1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH:0]       home_num,
    input  logic [ADDR_WIDTH:0]       nb_num,
    input  logic                      out_ready,
    output logic                      rden,
    output logic [ADDR_WIDTH-1:0]     home_rdaddr,
    output logic [ADDR_WIDTH-1:0]     nb_rdaddr,
    output logic                      pair_valid,
    output logic [ADDR_WIDTH-1:0]     pair_home_id,
    output logic [ADDR_WIDTH-1:0]     pair_nb_id,
    output logic                      busy,
    output logic                      done,
    output logic [PAIR_CNT_WIDTH-1:0] pair_count
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_NUM = CW'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // h is one bit wider than an address so that stepping past the last row is visible.
    typedef struct packed {
        logic [CW-1:0]         h;
        logic [ADDR_WIDTH-1:0] n;
    } pair_t;

    state_e                    state_q, state_d;
    logic [CW-1:0]             home_num_q, home_num_d, nb_num_q, nb_num_d;
    logic [ADDR_WIDTH-1:0]     h_q, h_d, n_q, n_d;
    logic [PAIR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CW-1:0]             hn, nn;
    pair_t                     cur, nxt, first;

    logic [RD_LATENCY-1:0]     vld_q;
    logic [ADDR_WIDTH-1:0]     hid_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]     nid_q [RD_LATENCY];

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v);
        return (v > MAX_NUM) ? MAX_NUM : v;
    endfunction

    function automatic pair_t step(input pair_t p, input logic [CW-1:0] nb);
        pair_t r;
        if ({1'b0, p.n} == nb - CW'(1)) begin
            r.h = p.h + CW'(1);
            r.n = '0;
        end else begin
            r.h = p.h;
            r.n = p.n + ADDR_WIDTH'(1);
        end
        return r;
    endfunction

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        home_num_d = home_num_q;
        nb_num_d   = nb_num_q;
        h_d        = h_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        rden       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        hn         = clamp(home_num);
        nn         = clamp(nb_num);
        cur.h      = {1'b0, h_q};
        cur.n      = n_q;
        nxt        = step(cur, nb_num_q);
`ifdef RL_SKIP_SELF_EN
        // (0,0) is always a self pair, and one step past a self pair never lands on another.
        first = step(pair_t'('0), nn);
        if (nxt.h == {1'b0, nxt.n}) nxt = step(nxt, nb_num_q);
`else
        first = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    home_num_d = hn;
                    nb_num_d   = nn;
                    cnt_d      = '0;
                    h_d        = '0;
                    n_d        = '0;
                    if (hn == '0 || nn == '0 || first.h >= hn) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                        h_d     = first.h[ADDR_WIDTH-1:0];
                        n_d     = first.n;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (out_ready) begin
                    rden  = 1'b1;
                    cnt_d = cnt_q + PAIR_CNT_WIDTH'(1);
                    if (nxt.h >= home_num_q) begin
                        state_d = DRAIN;
                    end else begin
                        h_d = nxt.h[ADDR_WIDTH-1:0];
                        n_d = nxt.n;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (vld_q == '0) state_d = DONE;
            end
            default: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            home_num_q <= '0;
            nb_num_q   <= '0;
            h_q        <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            home_num_q <= home_num_d;
            nb_num_q   <= nb_num_d;
            h_q        <= h_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
        end
    end

    // NOTE: the delay line is only a few flops and in-flight pairs must vanish on rst, so it is reset too.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                hid_q[i] <= '0;
                nid_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rden;
            hid_q[0] <= h_q;
            nid_q[0] <= n_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                hid_q[i] <= hid_q[i-1];
                nid_q[i] <= nid_q[i-1];
            end
        end
    end

    assign home_rdaddr  = h_q;
    assign nb_rdaddr    = n_q;
    assign pair_valid   = vld_q[RD_LATENCY-1];
    assign pair_home_id = hid_q[RD_LATENCY-1];
    assign pair_nb_id   = nid_q[RD_LATENCY-1];
    assign pair_count   = cnt_q;

endmodule
